// File: rtl/cordic_vector_iter.sv
// cordic_vector_iter
// ------------------
// Iterative vectoring-mode CORDIC. It converts a Cartesian sample (x, y) into
// magnitude and phase, with one micro-rotation per clock on a single shared
// datapath. The arctangent constants are the same 13 used by the
// rotation-mode pipeline.
//
// Build option:
//   CORDIC_GAIN_COMP_EN  - when defined, adds a COMP state. That state scales
//                          the final x by 0x26DD/2^14 (about 0.60724) so that
//                          mag_out is close to the true magnitude. When
//                          undefined, mag_out is the raw CORDIC x, which is
//                          about 1.64676 times the magnitude.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   in_valid   x_in/y_in valid        in_ready   block can accept a sample
//   x_in       signed x (WIDTH)        y_in       signed y (WIDTH)
//   out_valid  result valid            out_ready  consumer accepts result
//   mag_out    unsigned magnitude (WIDTH+2)
//   phase_out  signed phase (WIDTH+2), LSB = 2^-14 rad, range +/-pi
//   busy       high in every state except IDLE
//
// Latency: the sample is accepted at edge T, and out_valid rises at edge
// T+ITERATIONS+1 (T+ITERATIONS+2 with compensation).

module cordic_vector_iter #(
    parameter int WIDTH      = 15,
    parameter int ITERATIONS = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] mag_out,
    output logic [WIDTH+1:0] phase_out,
    output logic             busy
);

    localparam int W = WIDTH + 2;

    // k counts 0..ITERATIONS. The value ITERATIONS marks the cycle that
    // registers the finished result.
    localparam logic [3:0] K_END = 4'(ITERATIONS);

    localparam logic signed [W-1:0] HALF_PI = W'(25736);

    localparam logic [15:0] ATAN_ROM [13] = '{
        16'h3243, 16'h1DAC, 16'h0FAD, 16'h07F5, 16'h03FE, 16'h01FF, 16'h00FF,
        16'h007F, 16'h003F, 16'h001F, 16'h000F, 16'h0007, 16'h0003
    };

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        COMP,
        DONE
    } state_t;

    genvar gi;

    state_t              state_reg, state_next;
    logic                in_ready_reg;
    logic signed [W-1:0] x_reg, y_reg, z_reg;
    logic [3:0]          k_reg;
    logic                zero_reg;
    logic [W-1:0]        mag_reg, phase_reg;

    logic                accept;
    logic signed [W-1:0] x_ext, y_ext;
    logic signed [W-1:0] pre_x, pre_y, pre_z;
    logic signed [W-1:0] x_sh, y_sh, e_cur;
    logic signed [W-1:0] x_rot, y_rot, z_rot;
    logic signed [W-1:0] atan_tab [ITERATIONS];

    // Arctangent table, zero-extended to the working width.
    for (gi = 0; gi < ITERATIONS; gi++) begin : g_atan
        assign atan_tab[gi] = W'(ATAN_ROM[gi]);
    end

    assign accept = in_valid && in_ready_reg;

    assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
    assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};

    // Pre-rotation by +/-pi/2 brings the vector into the right half-plane.
    // The micro-rotations only converge there.
    always_comb begin
        pre_x = x_ext;
        pre_y = y_ext;
        pre_z = '0;
        if (x_ext[W-1]) begin
            if (!y_ext[W-1]) begin
                pre_x = y_ext;
                pre_y = -x_ext;
                pre_z = HALF_PI;
            end else begin
                pre_x = -y_ext;
                pre_y = x_ext;
                pre_z = -HALF_PI;
            end
        end
    end

    // One micro-rotation. Both shifts use the pre-update x and y.
    always_comb begin
        x_sh  = x_reg >>> k_reg;
        y_sh  = y_reg >>> k_reg;
        e_cur = '0;
        if (k_reg < K_END) begin
            e_cur = atan_tab[k_reg];
        end
        if (!y_reg[W-1]) begin
            x_rot = x_reg + y_sh;
            y_rot = y_reg - x_sh;
            z_rot = z_reg + e_cur;
        end else begin
            x_rot = x_reg - y_sh;
            y_rot = y_reg + x_sh;
            z_rot = z_reg - e_cur;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // Gain compensation: x * 0x26DD / 2^14 as a sum of truncated shifts.
    // Bit b of the constant contributes x >>> (14 - b).
    localparam logic [13:0] GAIN = 14'h26DD;

    logic signed [W-1:0] gain_term [14];
    logic signed [W-1:0] comp_sum;

    for (gi = 0; gi < 14; gi++) begin : g_gain
        if (GAIN[gi]) begin : g_on
            assign gain_term[gi] = x_reg >>> (14 - gi);
        end else begin : g_off
            assign gain_term[gi] = '0;
        end
    end

    always_comb begin
        comp_sum = '0;
        for (int i = 0; i < 14; i++) begin
            comp_sum = comp_sum + gain_term[i];
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (k_reg == K_END) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_next = COMP;
`else
                    state_next = DONE;
`endif
                end
            end
            COMP: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b0;
            x_reg        <= '0;
            y_reg        <= '0;
            z_reg        <= '0;
            k_reg        <= '0;
            zero_reg     <= 1'b0;
            mag_reg      <= '0;
            phase_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next == IDLE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x_reg    <= pre_x;
                        y_reg    <= pre_y;
                        z_reg    <= pre_z;
                        k_reg    <= '0;
                        // The zero input has no defined angle. Remember it so
                        // that the result can be forced to 0/0.
                        zero_reg <= (x_in == '0) && (y_in == '0);
                    end
                end
                ITER: begin
                    if (k_reg != K_END) begin
                        x_reg <= x_rot;
                        y_reg <= y_rot;
                        z_reg <= z_rot;
                        k_reg <= k_reg + 4'd1;
                    end else begin
`ifndef CORDIC_GAIN_COMP_EN
                        mag_reg   <= zero_reg ? '0 : x_reg;
                        phase_reg <= zero_reg ? '0 : z_reg;
`endif
                    end
                end
                COMP: begin
`ifdef CORDIC_GAIN_COMP_EN
                    mag_reg   <= zero_reg ? '0 : comp_sum;
                    phase_reg <= zero_reg ? '0 : z_reg;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign mag_out   = mag_reg;
    assign phase_out = phase_reg;

endmodule

// File: tb/tb_cordic_vector_iter.sv
`timescale 1ns/1ps
module tb_cordic_vector_iter;

    localparam int WIDTH      = 15;
    localparam int ITERATIONS = 13;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT     = ITERATIONS + 2;
    localparam bit COMP_ON = 1'b1;
`else
    localparam int LAT     = ITERATIONS + 1;
    localparam bit COMP_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] x_in = '0;
    logic [WIDTH-1:0] y_in = '0;
    logic             in_ready, out_valid, busy;
    logic [WIDTH+1:0] mag_out, phase_out;

    int n_cmp = 0;
    int n_bad = 0;

    cordic_vector_iter #(.WIDTH(WIDTH), .ITERATIONS(ITERATIONS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .mag_out(mag_out), .phase_out(phase_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: the vectoring algorithm on plain integers.
    function automatic void model(input int xi, input int yi, output int mag, output int ph);
        int e [13] = '{'h3243, 'h1DAC, 'h0FAD, 'h07F5, 'h03FE, 'h01FF, 'h00FF,
                       'h007F, 'h003F, 'h001F, 'h000F, 'h0007, 'h0003};
        int sh [9] = '{1, 4, 5, 7, 8, 10, 11, 12, 14};
        int x, y, z, xn, yn;
        if (xi >= 0)      begin x = xi;  y = yi;  z = 0;      end
        else if (yi >= 0) begin x = yi;  y = -xi; z = 25736;  end
        else              begin x = -yi; y = xi;  z = -25736; end
        for (int k = 0; k < ITERATIONS; k++) begin
            if (y >= 0) begin xn = x + (y >>> k); yn = y - (x >>> k); z = z + e[k]; end
            else        begin xn = x - (y >>> k); yn = y + (x >>> k); z = z - e[k]; end
            x = xn;
            y = yn;
        end
        if (COMP_ON) begin
            mag = 0;
            for (int i = 0; i < 9; i++) mag = mag + (x >>> sh[i]);
        end else begin
            mag = x;
        end
        ph = z;
        if (xi == 0 && yi == 0) begin mag = 0; ph = 0; end
    endfunction

    // Presents one sample, waits for the accept edge, then waits for out_valid.
    // Leaves the result pending (out_ready low) and returns the latency counted
    // from the accept edge.
    task automatic send_sample(input int xi, input int yi, output int lat, output int mag, output int ph);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
        end
        x_in = xi[WIDTH-1:0];
        y_in = yi[WIDTH-1:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        if (lat >= 60) begin
            n_cmp++; n_bad++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1 within 60 cycles", out_valid);
        end
        mag = int'(mag_out);
        ph  = int'($signed(phase_out));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if (mag_out !== '0)     begin n_bad++; $display("FAIL rst_mag: got %0d required 0", mag_out); end
        n_cmp++; if (phase_out !== '0)   begin n_bad++; $display("FAIL rst_phase: got %0d required 0", phase_out); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_release_in_ready: got %b required 1", in_ready); end
        $display("test_reset: outputs cleared, in_ready=%b after release", in_ready);
    endtask

    task automatic test_directed();
        int dx [7]   = '{10000, 0, -10000, 7071, -16384, 0, 3000};
        int dy [7]   = '{0, 10000, -1, 7071, -16384, 0, 4000};
        int ph_n [7] = '{0, 25736, -51472, 12868, -38604, 0, 15192};
        int mg_r [7] = '{16468, 16468, 16468, 16468, 38157, 0, 8234};
        int mg_c [7] = '{10000, 10000, 10000, 10000, 23170, 0, 5000};
        int lat, mag, ph, em, ep, nom, tol;
        for (int i = 0; i < 7; i++) begin
            send_sample(dx[i], dy[i], lat, mag, ph);
            model(dx[i], dy[i], em, ep);
            nom = COMP_ON ? mg_c[i] : mg_r[i];
            tol = COMP_ON ? ((i == 4) ? 10 : 6) : ((i == 4) ? 16 : 8);
            n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d required %0d", i, lat, LAT); end
            n_cmp++; if (mag !== em)  begin n_bad++; $display("FAIL dir_mag[%0d]: got %0d required %0d", i, mag, em); end
            n_cmp++; if (ph !== ep)   begin n_bad++; $display("FAIL dir_phase[%0d]: got %0d required %0d", i, ph, ep); end
            n_cmp++; if (mag > nom + tol || mag < nom - tol) begin
                n_bad++; $display("FAIL dir_mag_tol[%0d]: got %0d required %0d +/-%0d", i, mag, nom, tol);
            end
            n_cmp++; if (ph > ph_n[i] + 4 || ph < ph_n[i] - 4) begin
                n_bad++; $display("FAIL dir_phase_tol[%0d]: got %0d required %0d +/-4", i, ph, ph_n[i]);
            end
            $display("directed x=%0d y=%0d -> mag=%0d phase=%0d latency=%0d", dx[i], dy[i], mag, ph, lat);
            handshake();
        end
    endtask

    task automatic test_random();
        int xi, yi, lat, mag, ph, em, ep;
        for (int i = 0; i < 20; i++) begin
            xi = int'($urandom_range(32767)) - 16384;
            yi = int'($urandom_range(32767)) - 16384;
            send_sample(xi, yi, lat, mag, ph);
            model(xi, yi, em, ep);
            n_cmp++; if (mag !== em) begin n_bad++; $display("FAIL rnd_mag[%0d]: got %0d required %0d", i, mag, em); end
            n_cmp++; if (ph !== ep)  begin n_bad++; $display("FAIL rnd_phase[%0d]: got %0d required %0d", i, ph, ep); end
            $display("random x=%0d y=%0d -> mag=%0d phase=%0d", xi, yi, mag, ph);
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int xa, ya, xb, yb, lat, mag, ph, em, ep;
        logic [WIDTH+1:0] m0, p0;
        xa = int'($urandom_range(32767)) - 16384;
        ya = int'($urandom_range(32767)) - 16384;
        xb = int'($urandom_range(32767)) - 16384;
        yb = int'($urandom_range(32767)) - 16384;
        send_sample(xa, ya, lat, mag, ph);
        model(xa, ya, em, ep);
        n_cmp++; if (mag !== em) begin n_bad++; $display("FAIL bp_mag_a: got %0d required %0d", mag, em); end
        n_cmp++; if (ph !== ep)  begin n_bad++; $display("FAIL bp_phase_a: got %0d required %0d", ph, ep); end
        m0 = mag_out;
        p0 = phase_out;
        // A second sample is offered while the result is still pending.
        x_in = xb[WIDTH-1:0];
        y_in = yb[WIDTH-1:0];
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || mag_out !== m0 || phase_out !== p0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b mag=%0d ph=%0d required 1 0 %0d %0d",
                         c, out_valid, in_ready, mag_out, phase_out, m0, p0);
            end
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || mag_out !== m0 || phase_out !== p0) begin
            n_bad++;
            $display("FAIL bp_release: got valid=%b ready=%b busy=%b mag=%0d required 0 1 0 %0d",
                     out_valid, in_ready, busy, mag_out, m0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_accept: got busy=%b ready=%b required 1 0", busy, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        model(xb, yb, em, ep);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL bp_latency_b: got %0d required %0d", lat, LAT); end
        n_cmp++; if (int'(mag_out) !== em) begin n_bad++; $display("FAIL bp_mag_b: got %0d required %0d", mag_out, em); end
        n_cmp++; if (int'($signed(phase_out)) !== ep) begin
            n_bad++; $display("FAIL bp_phase_b: got %0d required %0d", $signed(phase_out), ep);
        end
        $display("backpressure: held 20 cycles, second sample x=%0d y=%0d -> mag=%0d", xb, yb, mag_out);
        handshake();
    endtask

    task automatic test_reset_abort();
        int n, seen, lat, mag, ph, em, ep;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        x_in = 15'd9000;
        y_in = 15'd1234;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || mag_out !== '0 || phase_out !== '0) begin
            n_bad++;
            $display("FAIL abort_clear: got ready=%b valid=%b busy=%b mag=%0d ph=%0d required all 0",
                     in_ready, out_valid, busy, mag_out, phase_out);
        end
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d valid cycles required 0", seen); end
        send_sample(3000, 4000, lat, mag, ph);
        model(3000, 4000, em, ep);
        n_cmp++; if (mag !== em) begin n_bad++; $display("FAIL abort_next_mag: got %0d required %0d", mag, em); end
        n_cmp++; if (ph !== ep)  begin n_bad++; $display("FAIL abort_next_phase: got %0d required %0d", ph, ep); end
        n_cmp++; if (mag > (COMP_ON ? 5006 : 8242) || mag < (COMP_ON ? 4994 : 8226)) begin
            n_bad++; $display("FAIL abort_next_mag_tol: got %0d required %0d +/-tol", mag, COMP_ON ? 5000 : 8234);
        end
        $display("reset_abort: aborted sample dropped, next x=3000 y=4000 -> mag=%0d phase=%0d", mag, ph);
        handshake();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
